ram512_arbiter: RTL and testbench

// - Two-requester round-robin arbiter that shares one RAM512 (512 x 16, comb read, clocked write).
// - Grants at most one access (read or write) per cycle; drives the RAM512 in_i/load_i/address_i.
// - Captures read data from the RAM512 out_o into a register; returns it one cycle later with a valid strobe.
// - Sits between CPU-side/DMA-side masters and a single RAM512 instance.
//

---
 rtl/ram512_arbiter.sv | 136 +++++++++++++
 tb/tb_ram512_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram512_arbiter.sv
// Round-robin two-port arbiter in front of one RAM512; read data registered, rvalid 1 cycle after grant.
// No response backpressure; ready is combinational. Optional power-on clear sweep: RAM512_ARB_CLEAR_EN.
module ram512_arbiter #(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic [DATA_W-1:0] ram_in_o,
  output logic              ram_load_o,
  output logic [ADDR_W-1:0] ram_address_o,
`ifdef RAM512_ARB_CLEAR_EN
  output logic              clear_done_o,
`endif
  input  logic [DATA_W-1:0] ram_out_i
);

  logic              serve;
  logic              clearing;
  logic [ADDR_W-1:0] clr_addr;
  logic              ptr_q;      // 0: A has priority, 1: B has priority
  logic              grant_a;
  logic              grant_b;
  logic              a_rvalid_q;
  logic              b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

`ifdef RAM512_ARB_CLEAR_EN
  typedef enum logic {S_CLEAR, S_SERVE} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] clr_cnt_d;
  logic              clear_done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_done_q <= (state_d == S_SERVE);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    serve     = 1'b0;
    clearing  = 1'b0;
    clr_addr  = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clearing  = ~rst_i;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = S_SERVE;
      end
      default: serve = 1'b1;
    endcase
  end

  assign clear_done_o = clear_done_q;
`else
  assign serve    = 1'b1;
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  // Reset gates the grants so ready/load drop the instant rst_i rises.
  assign grant_a = serve & ~rst_i & a_valid_i & (~b_valid_i | ~ptr_q);
  assign grant_b = serve & ~rst_i & b_valid_i & (~a_valid_i |  ptr_q);

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;

  always_comb begin
    ram_load_o    = 1'b0;
    ram_address_o = '0;
    ram_in_o      = '0;
    if (grant_a) begin
      ram_load_o    = a_we_i;
      ram_address_o = a_addr_i;
      ram_in_o      = a_wdata_i;
    end else if (grant_b) begin
      ram_load_o    = b_we_i;
      ram_address_o = b_addr_i;
      ram_in_o      = b_wdata_i;
    end else if (clearing) begin
      ram_load_o    = 1'b1;
      ram_address_o = clr_addr;
      ram_in_o      = CLEAR_VAL;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      if (grant_a)      ptr_q <= 1'b1;
      else if (grant_b) ptr_q <= 1'b0;
      a_rvalid_q <= grant_a & ~a_we_i;
      b_rvalid_q <= grant_b & ~b_we_i;
      if (grant_a & ~a_we_i) a_rdata_q <= ram_out_i;
      if (grant_b & ~b_we_i) b_rdata_q <= ram_out_i;
    end
  end

  assign a_rvalid_o = a_rvalid_q;
  assign b_rvalid_o = b_rvalid_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;

endmodule

// File: tb/tb_ram512_arbiter.sv
// Directed bench for ram512_arbiter with a behavioural RAM512 (comb read, clocked write).
module tb_ram512_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        a_valid, a_ready, a_we, a_rvalid;
  logic [8:0]  a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic        b_valid, b_ready, b_we, b_rvalid;
  logic [8:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [15:0] ram_in, ram_out;
  logic        ram_load;
  logic [8:0]  ram_address;
`ifdef RAM512_ARB_CLEAR_EN
  logic        clear_done;
`endif

  logic [15:0] mem [0:511];
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  ram512_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_we_i(a_we), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_we_i(b_we), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .ram_in_o(ram_in), .ram_load_o(ram_load), .ram_address_o(ram_address),
`ifdef RAM512_ARB_CLEAR_EN
    .clear_done_o(clear_done),
`endif
    .ram_out_i(ram_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests just after the edge, then move to mid-cycle for checks.
  task automatic step(input logic av, input logic aw, input logic [8:0] aa, input logic [15:0] ad,
                      input logic bv, input logic bw, input logic [8:0] ba, input logic [15:0] bd);
    @(posedge clk);
    #1;
    a_valid = av; a_we = aw; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_we = bw; b_addr = ba; b_wdata = bd;
    #4;
  endtask

  initial begin
    rst_i = 1'b1;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 9'h0AA; a_wdata = 16'hFFFF;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 9'h055; b_wdata = 16'h0;
    #12;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_load", ram_load, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_in", ram_in, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0;
`ifdef RAM512_ARB_CLEAR_EN
    repeat (520) @(posedge clk);
`endif

    // Write A 005=BEEF, then preload 010 and 1F0 for later reads
    step(1, 1, 9'h005, 16'hBEEF, 0, 0, 9'h0, 16'h0);
    chk("wr_a_ready", a_ready, 1);
    chk("wr_load", ram_load, 1);
    chk("wr_addr", ram_address, 9'h005);
    chk("wr_in", ram_in, 16'hBEEF);
    step(1, 1, 9'h010, 16'h1111, 0, 0, 9'h0, 16'h0);
    step(1, 1, 9'h1F0, 16'h2222, 0, 0, 9'h0, 16'h0);
    chk("wr_no_rvalid", a_rvalid, 0);

    // Read A 005
    step(1, 0, 9'h005, 16'h0, 0, 0, 9'h0, 16'h0);
    chk("rd_a_ready", a_ready, 1);
    chk("rd_load", ram_load, 0);
    chk("rd_addr", ram_address, 9'h005);
    chk("rd_rvalid_early", a_rvalid, 0);
    step(0, 0, 9'h0, 16'h0, 0, 0, 9'h0, 16'h0);
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 16'hBEEF);
    chk("rd_b_rvalid", b_rvalid, 0);
    chk("idle_addr", ram_address, 0);
    step(0, 0, 9'h0, 16'h0, 0, 0, 9'h0, 16'h0);
    chk("rd_rvalid_pulse", a_rvalid, 0);
    chk("rd_rdata_hold", a_rdata, 16'hBEEF);

    // Reset mid-read: pointer is at B before reset
    step(1, 0, 9'h010, 16'h0, 0, 0, 9'h0, 16'h0);
    @(posedge clk);
    #1 rst_i = 1'b1;
    #1;
    chk("mid_rst_rvalid", a_rvalid, 0);
    chk("mid_rst_rdata", a_rdata, 0);
    chk("mid_rst_ready", a_ready, 0);
    chk("mid_rst_load", ram_load, 0);
    a_valid = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0;
`ifdef RAM512_ARB_CLEAR_EN
    repeat (520) @(posedge clk);
`endif

    // Both valid: grants A,B,A,B starting with A
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 9'h010, 16'h0, 1, 0, 9'h1F0, 16'h0);
      chk($sformatf("alt_a_ready%0d", i), a_ready, (i % 2 == 0));
      chk($sformatf("alt_b_ready%0d", i), b_ready, (i % 2 == 1));
      chk($sformatf("alt_addr%0d", i), ram_address, (i % 2 == 0) ? 9'h010 : 9'h1F0);
      if (i > 0) begin
        chk($sformatf("alt_a_rvalid%0d", i), a_rvalid, (i % 2 == 1));
        chk($sformatf("alt_b_rvalid%0d", i), b_rvalid, (i % 2 == 0));
      end
    end
    step(0, 0, 9'h0, 16'h0, 0, 0, 9'h0, 16'h0);
    chk("alt_b_rvalid_last", b_rvalid, 1);
    chk("alt_a_rdata", a_rdata, 16'h1111);
    chk("alt_b_rdata", b_rdata, 16'h2222);

    // Only B valid for 4 cycles: never stalls
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 9'h0, 16'h0, 1, 0, 9'h005, 16'h0);
      chk($sformatf("bonly_b_ready%0d", i), b_ready, 1);
      chk($sformatf("bonly_a_ready%0d", i), a_ready, 0);
    end

    // A writes 100=1234 and B reads 100 together: A first, then B sees new data
    step(1, 1, 9'h100, 16'h1234, 1, 0, 9'h100, 16'h0);
    chk("col_a_ready", a_ready, 1);
    chk("col_b_ready", b_ready, 0);
    chk("col_b_rdata_prev", b_rdata, 16'hBEEF);
    step(0, 0, 9'h0, 16'h0, 1, 0, 9'h100, 16'h0);
    chk("col_b_ready2", b_ready, 1);
    step(0, 0, 9'h0, 16'h0, 0, 0, 9'h0, 16'h0);
    chk("col_b_rvalid", b_rvalid, 1);
    chk("col_b_rdata", b_rdata, 16'h1234);

`ifdef RAM512_ARB_CLEAR_EN
    begin
      int ready_hits;
      ready_hits = 0;
      step(1, 1, 9'h1FF, 16'h5555, 0, 0, 9'h0, 16'h0);
      @(posedge clk);
      #1 rst_i = 1'b1;
      a_valid = 1'b1; a_we = 1'b0; a_addr = 9'h1FF;
      @(posedge clk);
      #1 rst_i = 1'b0;
      #4;
      chk("clr_done_start", clear_done, 0);
      for (int i = 0; i < 512; i++) begin
        if (a_ready) ready_hits++;
        #10;
      end
      chk("clr_ready_hits", ready_hits, 0);
      chk("clr_done", clear_done, 1);
      chk("clr_ready_after", a_ready, 1);
      #10;
      chk("clr_rvalid", a_rvalid, 1);
      chk("clr_rdata", a_rdata, 16'h0000);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
